// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder
// Carry-select adder split into WIDTH/BLOCK blocks, with one pipeline stage
// per block. Stage s adds block s twice (carry-in 0 and carry-in 1) and uses
// the carry registered by stage s-1 to pick one of the two results. Operand
// bits for later blocks travel forward in skew registers. Finished sum bits
// travel forward in deskew registers. The whole pipeline holds while the
// output is valid but not accepted.
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NBLK = WIDTH / BLOCK;

  // Reject block geometries that cannot tile the word.
  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_geometry
    $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // Per-stage registered state. Stage NBLK-1 drives the outputs.
  logic [WIDTH-1:0] a_q     [NBLK];  // skew: operand A, still-pending blocks
  logic [WIDTH-1:0] b_q     [NBLK];  // skew: effective operand B
  logic [WIDTH-1:0] sum_q   [NBLK];  // deskew: finished sum blocks
  logic             carry_q [NBLK];  // carry out of the block just finished
  logic             valid_q [NBLK];  // stage holds a real operation
  logic             ovf_q;

  // Next-state values, one entry per stage.
  logic [WIDTH-1:0] a_d     [NBLK];
  logic [WIDTH-1:0] b_d     [NBLK];
  logic [WIDTH-1:0] sum_d   [NBLK];
  logic             carry_d [NBLK];
  logic             valid_d [NBLK];
  logic             ovf_d;

  // Subtraction is A + ~B + 1. The mode and Cin are folded in at entry, so
  // each operation carries its own mode through the pipeline.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             advance;

  assign b_eff = sub ? ~B : B;
  assign c_eff = sub ? 1'b1 : Cin;

  // The pipeline holds only when a finished result is not being taken.
  // A held pipeline cannot accept a new operation.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar s = 0; s < NBLK; s++) begin : g_stage
    localparam int LO = s * BLOCK;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic             c_in;
    logic             v_in;
    logic [BLOCK-1:0] blk_a;
    logic [BLOCK-1:0] blk_b;
    logic [BLOCK:0]   csum0;
    logic [BLOCK:0]   csum1;
    logic [BLOCK:0]   csel;
    logic [WIDTH-1:0] sum_blk;

    if (s == 0) begin : g_head
      // The first stage takes its operands straight from the ports.
      assign a_in   = A;
      assign b_in   = b_eff;
      assign sum_in = '0;
      assign c_in   = c_eff;
      assign v_in   = in_valid;
    end else begin : g_body
      // Later stages take their operands from the previous stage registers.
      assign a_in   = a_q[s-1];
      assign b_in   = b_q[s-1];
      assign sum_in = sum_q[s-1];
      assign c_in   = carry_q[s-1];
      assign v_in   = valid_q[s-1];
    end

    assign blk_a = a_in[LO +: BLOCK];
    assign blk_b = b_in[LO +: BLOCK];

    // Compute both possible block sums ahead of time.
    // The incoming carry only selects between them.
    assign csum0 = {1'b0, blk_a} + {1'b0, blk_b};
    assign csum1 = {1'b0, blk_a} + {1'b0, blk_b} + {{BLOCK{1'b0}}, 1'b1};
    assign csel  = c_in ? csum1 : csum0;

    // Merge this block's result into the finished sum bits carried forward.
    always_comb begin
      // NOTE: assign the whole word first so that every bit has a value on
      // every path. Without that default, this always_comb would infer a latch.
      sum_blk             = sum_in;
      sum_blk[LO +: BLOCK] = csel[BLOCK-1:0];
    end

    assign a_d[s]     = a_in;
    assign b_d[s]     = b_in;
    assign sum_d[s]   = sum_blk;
    assign carry_d[s] = csel[BLOCK];
    assign valid_d[s] = v_in;

    if (s == NBLK - 1) begin : g_ovf
      // The carry into the MSB is a ^ b ^ sum at that bit.
      // Overflow is that carry XOR the carry out of the MSB.
      assign ovf_d = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ sum_blk[WIDTH-1]
                   ^ csel[BLOCK];
    end
  end

  // Pipeline registers: reset empties the pipeline. Otherwise every stage
  // shifts forward together unless the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are cleared along with the valid bits. This keeps
      // sum/Cout/ovf at zero after reset, not at leftovers from aborted work.
      for (int s = 0; s < NBLK; s++) begin
        a_q[s]     <= '0;
        b_q[s]     <= '0;
        sum_q[s]   <= '0;
        carry_q[s] <= 1'b0;
        valid_q[s] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage sample the
      // pre-edge value of the stage before it, as a real shift register does.
      for (int s = 0; s < NBLK; s++) begin
        a_q[s]     <= a_d[s];
        b_q[s]     <= b_d[s];
        sum_q[s]   <= sum_d[s];
        carry_q[s] <= carry_d[s];
        valid_q[s] <= valid_d[s];
      end
      ovf_q <= ovf_d;
    end
  end

  assign sum       = sum_q[NBLK-1];
  assign Cout      = carry_q[NBLK-1];
  assign ovf       = ovf_q;
  assign out_valid = valid_q[NBLK-1];

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Testbench for pipelined_csel_adder.
// Three configurations (16/4, 8/1, 32/8) share one stimulus stream.
// Each has an arithmetic scoreboard. Directed cycle-exact checks use the
// 16/4 instance.
module tb_pipelined_csel_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_cin;
  logic        op_sub;
  logic        in_valid;
  logic        out_ready;

  logic        rdy16, cout16, ovf16, ov16;
  logic [15:0] sum16;
  logic        rdy8, cout8, ovf8, ov8;
  logic [7:0]  sum8;
  logic        rdy32, cout32, ovf32, ov32;
  logic [31:0] sum32;

  logic        rdy_w [3];
  logic        ov_w  [3];
  logic [33:0] res_w [3];

  int checks   = 0;
  int failures = 0;

  // Operand sets for back-to-back, stall and reset sequences.
  logic [15:0] bb_a   [4] = '{16'h1234, 16'h00FF, 16'h0005, 16'hAAAA};
  logic [15:0] bb_b   [4] = '{16'h1111, 16'h0001, 16'h0007, 16'h5555};
  logic        bb_cin [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic        bb_sub [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] bb_exp [4] = '{16'h2345, 16'h0101, 16'hFFFE, 16'hFFFF};

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
    .clk(clk), .reset(reset), .A(op_a[15:0]), .B(op_b[15:0]), .Cin(op_cin),
    .sub(op_sub), .in_valid(in_valid), .in_ready(rdy16), .sum(sum16),
    .Cout(cout16), .ovf(ovf16), .out_valid(ov16), .out_ready(out_ready));

  pipelined_csel_adder #(.WIDTH(8), .BLOCK(1)) u_dut8 (
    .clk(clk), .reset(reset), .A(op_a[7:0]), .B(op_b[7:0]), .Cin(op_cin),
    .sub(op_sub), .in_valid(in_valid), .in_ready(rdy8), .sum(sum8),
    .Cout(cout8), .ovf(ovf8), .out_valid(ov8), .out_ready(out_ready));

  pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
    .clk(clk), .reset(reset), .A(op_a), .B(op_b), .Cin(op_cin),
    .sub(op_sub), .in_valid(in_valid), .in_ready(rdy32), .sum(sum32),
    .Cout(cout32), .ovf(ovf32), .out_valid(ov32), .out_ready(out_ready));

  assign rdy_w[0] = rdy16;
  assign rdy_w[1] = rdy8;
  assign rdy_w[2] = rdy32;
  assign ov_w[0]  = ov16;
  assign ov_w[1]  = ov8;
  assign ov_w[2]  = ov32;
  assign res_w[0] = {ovf16, cout16, 16'h0000, sum16};
  assign res_w[1] = {ovf8, cout8, 24'h000000, sum8};
  assign res_w[2] = {ovf32, cout32, sum32};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain w-bit arithmetic on the effective operands.
  // The result is packed as {ovf, cout, sum (zero-extended to 32 bits)}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic sb);
    logic [63:0] mask, ae, be, full;
    logic        sgn_a, sgn_b, sgn_s, cy, ov;
    mask  = (64'd1 << w) - 64'd1;
    ae    = {32'h0, a} & mask;
    be    = sb ? (~{32'h0, b}) & mask : {32'h0, b} & mask;
    full  = ae + be + ((sb || cin) ? 64'd1 : 64'd0);
    sgn_a = ae[w-1];
    sgn_b = be[w-1];
    sgn_s = full[w-1];
    cy    = full[w];
    ov    = (sgn_a == sgn_b) && (sgn_s != sgn_a);
    return {ov, cy, full[31:0] & mask[31:0]};
  endfunction

  // One scoreboard per configuration. Inputs and outputs are sampled on the
  // falling edge, where they are stable for the next rising edge.
  for (genvar k = 0; k < 3; k++) begin : g_sb
    localparam int W = (k == 0) ? 16 : (k == 1) ? 8 : 32;
    logic [33:0] q[$];
    logic [33:0] e;
    always @(negedge clk) begin
      if (reset) begin
        q.delete();
      end else begin
        if (ov_w[k] && out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("sb%0d_extra_result", W), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("sb%0d_result", W), {30'h0, res_w[k]}, {30'h0, e});
          end
        end
        if (in_valid && rdy_w[k])
          q.push_back(model(W, op_a, op_b, op_cin, op_sub));
      end
    end
  end

  task automatic set_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sb);
    op_a   = {16'h0000, a};
    op_b   = {16'h0000, b};
    op_cin = cin;
    op_sub = sb;
  endtask

  // Issue one operation into an empty pipeline and check the cycle it emerges.
  task automatic run_single(input string tag, input logic [15:0] a,
                            input logic [15:0] b, input logic cin,
                            input logic sb, input logic [15:0] es,
                            input logic ec, input logic eo);
    int n;
    set_op(a, b, cin, sb);
    in_valid = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) in_valid = 1'b0;
      n = i;
      if (ov16) break;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_sum"}, {48'h0, sum16}, {48'h0, es});
    check({tag, "_cout"}, {63'h0, cout16}, {63'h0, ec});
    check({tag, "_ovf"}, {63'h0, ovf16}, {63'h0, eo});
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back acceptances. Returns just after the fourth edge.
  task automatic load4();
    for (int i = 0; i < 4; i++) begin
      set_op(bb_a[i], bb_b[i], bb_cin[i], bb_sub[i]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int stale;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_op(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", {48'h0, sum16}, 64'd0);
    check("reset_cout", {63'h0, cout16}, 64'd0);
    check("reset_ovf", {63'h0, ovf16}, 64'd0);
    check("reset_out_valid", {63'h0, ov16}, 64'd0);
    check("reset_in_ready", {63'h0, rdy16}, 64'd1);
    reset = 1'b0;

    // First operation goes in on the first edge after reset is released.
    run_single("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("max_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("min_minus_1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back: results on four consecutive cycles.
    load4();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b%0d_valid", i), {63'h0, ov16}, 64'd1);
      check($sformatf("b2b%0d_sum", i), {48'h0, sum16}, {48'h0, bb_exp[i]});
      check($sformatf("b2b%0d_cout", i), {63'h0, cout16}, 64'd0);
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    check("b2b_drained", {63'h0, ov16}, 64'd0);

    // Stall with a full pipeline for three cycles.
    load4();
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", {63'h0, rdy16}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_sum", i), {48'h0, sum16}, {48'h0, bb_exp[0]});
      check($sformatf("stall%0d_valid", i), {63'h0, ov16}, 64'd1);
      check($sformatf("stall%0d_in_ready", i), {63'h0, rdy16}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {63'h0, rdy16}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("unstall%0d_valid", i), {63'h0, ov16}, 64'd1);
      check($sformatf("unstall%0d_sum", i), {48'h0, sum16}, {48'h0, bb_exp[i]});
      @(posedge clk);
      #1;
    end
    check("unstall_drained", {63'h0, ov16}, 64'd0);

    // Reset with operations in flight and a result on the output.
    load4();
    check("midrst_pre_valid", {63'h0, ov16}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_sum", {48'h0, sum16}, 64'd0);
    check("midrst_cout", {63'h0, cout16}, 64'd0);
    check("midrst_ovf", {63'h0, ovf16}, 64'd0);
    check("midrst_out_valid", {63'h0, ov16}, 64'd0);
    check("midrst_in_ready", {63'h0, rdy16}, 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    stale = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ov16) stale++;
    end
    check("midrst_stale_results", 64'(stale), 64'd0);

    // Random add/sub with bubbles and stalls. All three configurations are
    // checked by their scoreboards.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       op_a = 32'hFFFF_FFFF;
        1:       op_a = 32'h8000_0000 >> ($urandom_range(0, 2) * 8);
        default: op_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       op_b = 32'h0000_0001;
        1:       op_b = 32'h7FFF_FFFF >> ($urandom_range(0, 2) * 8);
        default: op_b = $urandom;
      endcase
      op_cin    = ($urandom_range(0, 1) == 1);
      op_sub    = ($urandom_range(0, 1) == 1);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("drain16_pending", 64'(g_sb[0].q.size()), 64'd0);
    check("drain8_pending", 64'(g_sb[1].q.size()), 64'd0);
    check("drain32_pending", 64'(g_sb[2].q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
